// File: rtl/io_pkg.sv
// io_pkg
// Shared definitions for the input conditioner slice: the per-channel
// debounce state type, default timing values and a helper that sizes the
// shared tick counter.
// No ports (package).

package io_pkg;

   // Per-channel debounce state: settled at q, or watching a difference.
   typedef enum logic {
      STABLE   = 1'b0,
      CHANGING = 1'b1
   } chan_state_e;

   // 1 ms tick at 50 MHz, ten ticks of continuous difference to accept a change.
   localparam int TICK_DIV_DEFAULT     = 50000;
   localparam int STABLE_TICKS_DEFAULT = 10;

   // Width of the tick counter for the default divider.
   localparam int TICK_CNT_W = $clog2(TICK_DIV_DEFAULT);

   // Width of a counter running 0..div-1; never narrower than one bit.
   function automatic int tick_cnt_width(input int div);
      return (div < 2) ? 1 : $clog2(div);
   endfunction

endpackage

// File: rtl/io_input_conditioner_debounce_channel.sv
// debounce_channel
// One conditioned input bit: 2-FF synchroniser, two-state debounce FSM
// driven by the shared tick, and a registered rise pulse.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   raw    raw level, already active-high, asynchronous to clk
//   tick   one-cycle strobe from the shared tick generator
//   q      debounced level (registered)
//   rise   one-cycle pulse in the cycle after q goes 0->1

module debounce_channel
   import io_pkg::*;
#(
   parameter int STABLE_TICKS = STABLE_TICKS_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   input  logic tick,
   output logic q,
   output logic rise
);

   localparam logic [3:0] CNT_LAST = 4'(STABLE_TICKS - 1);

   logic        sync_meta;
   logic        sync;
   chan_state_e state;
   chan_state_e state_next;
   logic        q_next;
   logic [3:0]  cnt;
   logic [3:0]  cnt_next;
   logic        q_dly;

   // Two-flop synchroniser bringing the raw level into the clock domain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_meta <= 1'b0;
         sync      <= 1'b0;
      end else begin
         sync_meta <= raw;
         sync      <= sync_meta;
      end
   end

   // Debounce state, accepted level and tick count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= STABLE;
         q     <= 1'b0;
         cnt   <= 4'd0;
      end else begin
         state <= state_next;
         q     <= q_next;
         cnt   <= cnt_next;
      end
   end

   // Next-state logic. The tick that coincides with entering CHANGING is
   // deliberately ignored, so q only flips after STABLE_TICKS whole ticks
   // of uninterrupted difference.
   always_comb begin
      state_next = state;
      q_next     = q;
      cnt_next   = cnt;
      case (state)
         STABLE: begin
            if (sync != q) begin
               state_next = CHANGING;
               cnt_next   = 4'd0;
            end
         end
         CHANGING: begin
            if (sync == q) begin
               state_next = STABLE;
               cnt_next   = 4'd0;
            end else if (tick) begin
               if (cnt == CNT_LAST) begin
                  q_next     = ~q;
                  state_next = STABLE;
                  cnt_next   = 4'd0;
               end else begin
                  cnt_next = cnt + 4'd1;
               end
            end
         end
         default: begin
            state_next = STABLE;
            cnt_next   = 4'd0;
         end
      endcase
   end

   // Rise pulse: registered so it appears the cycle after q goes high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_dly <= 1'b0;
         rise  <= 1'b0;
      end else begin
         q_dly <= q;
         rise  <= q & ~q_dly;
      end
   end

endmodule

// File: rtl/io_input_conditioner.sv
// io_input_conditioner
// Synchronises and debounces the board switches and push-buttons and presents
// them as clean 32-bit words to the load/store unit's input-peripheral region,
// plus one-cycle press pulses for event logic.
// Ports:
//   i_clk        system clock
//   i_rst_n      asynchronous active-low reset
//   i_sw_raw     raw switch levels (SW_W bits, asynchronous)
//   i_btn_raw    raw button levels (BTN_W bits, asynchronous, see BTN_ACTIVE_LOW)
//   o_io_sw      debounced switches, zero-extended to 32 bits
//   o_io_btn     debounced buttons in [BTN_W-1:0], 1 = pressed, rest zero
//   o_btn_pulse  one-cycle pulse per button press

module io_input_conditioner
   import io_pkg::*;
#(
   parameter int SW_W           = 18,
   parameter int BTN_W          = 4,
   parameter bit BTN_ACTIVE_LOW = 1'b1,
   parameter int TICK_DIV       = TICK_DIV_DEFAULT,
   parameter int STABLE_TICKS   = STABLE_TICKS_DEFAULT
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [SW_W-1:0]  i_sw_raw,
   input  logic [BTN_W-1:0] i_btn_raw,
   output logic [31:0]      o_io_sw,
   output logic [31:0]      o_io_btn,
   output logic [BTN_W-1:0] o_btn_pulse
);

   localparam int TICK_W = tick_cnt_width(TICK_DIV);

   logic [TICK_W-1:0] tick_cnt;
   logic              tick;
   logic [BTN_W-1:0]  btn_level;
   logic [SW_W-1:0]   sw_q;
   logic [SW_W-1:0]   sw_rise_unused;
   logic [BTN_W-1:0]  btn_q;

   // Shared tick generator: counts 0..TICK_DIV-1 and strobes on the last value.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         tick_cnt <= '0;
      end else if (tick) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + 1'b1;
      end
   end

   assign tick = (tick_cnt == TICK_W'(TICK_DIV - 1));

   // Buttons are made active-high before synchronisation.
   assign btn_level = BTN_ACTIVE_LOW ? ~i_btn_raw : i_btn_raw;

   for (genvar i = 0; i < SW_W; i++) begin : g_sw
      debounce_channel #(
         .STABLE_TICKS(STABLE_TICKS)
      ) u_chan (
         .clk  (i_clk),
         .rst_n(i_rst_n),
         .raw  (i_sw_raw[i]),
         .tick (tick),
         .q    (sw_q[i]),
         .rise (sw_rise_unused[i])
      );
   end

   for (genvar i = 0; i < BTN_W; i++) begin : g_btn
      debounce_channel #(
         .STABLE_TICKS(STABLE_TICKS)
      ) u_chan (
         .clk  (i_clk),
         .rst_n(i_rst_n),
         .raw  (btn_level[i]),
         .tick (tick),
         .q    (btn_q[i]),
         .rise (o_btn_pulse[i])
      );
   end

   // Zero-extend the debounced levels onto the 32-bit LSU words.
   always_comb begin
      o_io_sw               = '0;
      o_io_sw[SW_W-1:0]     = sw_q;
      o_io_btn              = '0;
      o_io_btn[BTN_W-1:0]   = btn_q;
   end

endmodule

// File: tb/tb_io_input_conditioner.sv
// tb_io_input_conditioner
// Directed and randomized stimulus for io_input_conditioner with
// TICK_DIV=4, STABLE_TICKS=3, checked every cycle against a timing model
// kept in the bench, plus literal expectations on the directed scenarios.
// No ports (top-level bench).

module tb_io_input_conditioner;

   localparam int SW_W         = 18;
   localparam int BTN_W        = 4;
   localparam int TICK_DIV     = 4;
   localparam int STABLE_TICKS = 3;
   localparam int N            = SW_W + BTN_W;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [SW_W-1:0]   sw_raw = '0;
   logic [BTN_W-1:0]  btn_raw = 4'hF;
   logic [31:0]       o_io_sw;
   logic [31:0]       o_io_btn;
   logic [BTN_W-1:0]  o_btn_pulse;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   io_input_conditioner #(
      .SW_W          (SW_W),
      .BTN_W         (BTN_W),
      .BTN_ACTIVE_LOW(1'b1),
      .TICK_DIV      (TICK_DIV),
      .STABLE_TICKS  (STABLE_TICKS)
   ) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_sw_raw   (sw_raw),
      .i_btn_raw  (btn_raw),
      .o_io_sw    (o_io_sw),
      .o_io_btn   (o_io_btn),
      .o_btn_pulse(o_btn_pulse)
   );

   // Reference model state. Cycle c is the interval ending at the c-th clock
   // edge after reset release; a tick falls in cycle c when (c+1) is a
   // multiple of TICK_DIV.
   bit          s1[N];
   bit          s2[N];
   bit          mq[N];
   bit          mq_prev[N];
   bit          mpulse[N];
   bit          differing[N];
   int          diff_start[N];
   int          cyc;
   logic [31:0] exp_sw;
   logic [31:0] exp_btn;
   logic [31:0] exp_pulse;

   function automatic int ticks_in(input int a, input int b);
      return (b + 1) / TICK_DIV - (a + 1) / TICK_DIV;
   endfunction

   // Model: a level change is accepted once the synchronised input has
   // differed continuously while STABLE_TICKS ticks occurred after the
   // first cycle of difference.
   always @(posedge clk) begin : model
      logic [N-1:0] lvl;
      lvl = {~btn_raw, sw_raw};
      if (!rst_n) begin
         for (int i = 0; i < N; i++) begin
            s1[i] = 1'b0; s2[i] = 1'b0; mq[i] = 1'b0; mq_prev[i] = 1'b0;
            mpulse[i] = 1'b0; differing[i] = 1'b0; diff_start[i] = 0;
         end
         cyc = 0;
      end else begin
         for (int i = 0; i < N; i++) begin
            mpulse[i]  = mq[i] & ~mq_prev[i];
            mq_prev[i] = mq[i];
            if (s2[i] != mq[i]) begin
               if (!differing[i]) begin
                  differing[i]  = 1'b1;
                  diff_start[i] = cyc;
               end else if (ticks_in(diff_start[i], cyc) >= STABLE_TICKS) begin
                  mq[i]        = ~mq[i];
                  differing[i] = 1'b0;
               end
            end else begin
               differing[i] = 1'b0;
            end
            s2[i] = s1[i];
            s1[i] = lvl[i];
         end
         cyc++;
      end
      exp_sw = '0; exp_btn = '0; exp_pulse = '0;
      for (int i = 0; i < SW_W; i++) exp_sw[i] = mq[i];
      for (int j = 0; j < BTN_W; j++) begin
         exp_btn[j]   = mq[SW_W + j];
         exp_pulse[j] = mpulse[SW_W + j];
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic checkRange(input string name, input int val, input int lo, input int hi);
      vectors++;
      if (val < lo || val > hi) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d expected %0d..%0d at %0t", name, val, lo, hi, $time);
      end
   endtask

   // Every cycle, 2 time units after the edge, compare DUT against the model.
   always @(posedge clk) begin
      #2;
      checkOutput("model_sw", o_io_sw, exp_sw);
      checkOutput("model_btn", o_io_btn, exp_btn);
      checkOutput("model_pulse", {28'b0, o_btn_pulse}, exp_pulse);
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic applyStimulus(input logic [SW_W-1:0] sw, input logic [BTN_W-1:0] btn);
      sw_raw  = sw;
      btn_raw = btn;
   endtask

   // Asserts reset for one clock edge and checks the outputs clear at once.
   task automatic resetPulse(input string tag);
      #1 rst_n = 1'b0;
      #1;
      checkOutput({tag, "_sw0"}, o_io_sw, 32'h0);
      checkOutput({tag, "_btn0"}, o_io_btn, 32'h0);
      checkOutput({tag, "_pulse0"}, {28'b0, o_btn_pulse}, 32'h0);
      step();
      #1 rst_n = 1'b1;
   endtask

   initial begin
      int k;
      logic [SW_W-1:0]  msk_sw;
      logic [BTN_W-1:0] msk_btn;
      $display("[TB] start");

      // Reset and idle.
      applyStimulus('0, 4'hF);
      step();
      resetPulse("init");
      repeat (100) step();
      checkOutput("idle_sw", o_io_sw, 32'h0);
      checkOutput("idle_btn", o_io_btn, 32'h0);
      checkOutput("idle_pulse", {28'b0, o_btn_pulse}, 32'h0);

      // Press button 0 and hold.
      applyStimulus('0, 4'hE);
      k = 0;
      while (o_io_btn[0] !== 1'b1 && k < 20) begin step(); k++; end
      checkRange("press_latency", k, 12, 16);
      checkOutput("press_btn", o_io_btn, 32'h1);
      checkOutput("press_pulse_early", {28'b0, o_btn_pulse}, 32'h0);
      step();
      checkOutput("press_pulse", {28'b0, o_btn_pulse}, 32'h1);
      step();
      checkOutput("press_pulse_end", {28'b0, o_btn_pulse}, 32'h0);

      // Reset while the button is held: re-debounced from scratch.
      resetPulse("midhold");
      k = 0;
      while (o_io_btn[0] !== 1'b1 && k < 20) begin step(); k++; end
      checkRange("rehold_latency", k, 1, 16);
      step();
      checkOutput("rehold_pulse", {28'b0, o_btn_pulse}, 32'h1);

      // Switch 3 bouncing every 3 cycles, then settling high.
      for (int c = 0; c < 60; c++) begin
         if (c % 3 == 0) applyStimulus(sw_raw ^ 18'h8, btn_raw);
         step();
         checkOutput("bounce_sw", o_io_sw, 32'h0);
      end
      applyStimulus(18'h8, btn_raw);
      k = 0;
      while (o_io_sw === 32'h0 && k < 20) begin step(); k++; end
      checkRange("settle_latency", k, 1, 16);
      checkOutput("settle_sw", o_io_sw, 32'h8);

      // Back to idle, then everything at once.
      applyStimulus('0, 4'hF);
      repeat (30) step();
      checkOutput("idle2_sw", o_io_sw, 32'h0);
      checkOutput("idle2_btn", o_io_btn, 32'h0);
      applyStimulus(18'h3FFFF, 4'h0);
      k = 0;
      while (o_io_sw === 32'h0 && k < 20) begin step(); k++; end
      checkRange("all_latency", k, 12, 16);
      checkOutput("all_sw", o_io_sw, 32'h0003FFFF);
      checkOutput("all_btn", o_io_btn, 32'hF);
      step();
      checkOutput("all_pulse", {28'b0, o_btn_pulse}, 32'hF);
      step();
      checkOutput("all_pulse_end", {28'b0, o_btn_pulse}, 32'h0);

      // Release button 1: falls after full latency, no pulse.
      applyStimulus(18'h3FFFF, 4'h2);
      k = 0;
      while (o_io_btn[1] !== 1'b0 && k < 20) begin
         step(); k++;
         checkOutput("release_pulse", {28'b0, o_btn_pulse}, 32'h0);
      end
      checkRange("release_latency", k, 12, 16);
      checkOutput("release_btn", o_io_btn, 32'hD);
      step();
      checkOutput("release_pulse_after", {28'b0, o_btn_pulse}, 32'h0);

      // Random sparse flips with random hold times, occasional reset.
      for (int r = 0; r < 300; r++) begin
         msk_sw  = SW_W'($urandom & $urandom & $urandom);
         msk_btn = BTN_W'($urandom & $urandom);
         applyStimulus(sw_raw ^ msk_sw, btn_raw ^ msk_btn);
         repeat ($urandom_range(1, 20)) step();
         if (r % 75 == 40) resetPulse("rand");
      end
      repeat (20) step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
